idex_hazard_stage: RTL

- ID/EX pipeline register plus load-use hazard control for the 5-stage core.
- Sits between decode and the EX-stage forwarding logic; supplies the rs1/rs2, rd, operand data and control bits that forwarding and the ALU consume.
- Generates the IF/ID stall, inserts bubbles, honours branch flush and EX multicycle hold.
- Refreshes held operands from writeback so no result is lost while the instruction is stalled.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/load_use_detect.sv | 27 ++
 rtl/idex_hazard_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and widths for the 5-stage core: register/data widths, ALU opcodes,
// the packed control bundle carried down the pipe, and the writeback-match helper.
package riscv_pkg;

  localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;
  localparam int RISC_V_DATA_WIDTH           = 32;

  typedef logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_idx_t;
  typedef logic [RISC_V_DATA_WIDTH-1:0]           data_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic    reg_w;
    logic    mem_r;
    logic    mem_w;
    logic    alu_src;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_w:   1'b0,
    mem_r:   1'b0,
    mem_w:   1'b0,
    alu_src: 1'b0,
    alu_op:  ALU_ADD
  };

  // True when a committing writeback targets the given source register (x0 never matches).
  function automatic logic wb_hit(input logic wb_w, input reg_idx_t wb_idx, input reg_idx_t rs);
    return wb_w && (wb_idx != {REGISTER_FILE_ADDRESS_WIDTH{1'b0}}) && (wb_idx == rs);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: an instruction in decode reads a register
// that the load currently in EX has not yet produced.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic     id_valid,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  logic     id_uses_rs1,
  input  logic     id_uses_rs2,
  input  logic     ex_valid,
  input  logic     ex_mem_r,
  input  reg_idx_t ex_rd,
  output logic     lu
);

  logic rs1_match_s;
  logic rs2_match_s;

  assign rs1_match_s = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match_s = id_uses_rs2 && (id_rs2 == ex_rd);

  assign lu = id_valid && ex_valid && ex_mem_r
              && (ex_rd != {REGISTER_FILE_ADDRESS_WIDTH{1'b0}})
              && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, EX multicycle
// hold with writeback refresh of held operands, and saturating performance counters.
module idex_hazard_stage
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   id_valid,
  input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] id_rs1,
  input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] id_rs2,
  input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] id_rd,
  input  logic                                   id_uses_rs1,
  input  logic                                   id_uses_rs2,
  input  logic [RISC_V_DATA_WIDTH-1:0]           id_reg_r0,
  input  logic [RISC_V_DATA_WIDTH-1:0]           id_reg_r1,
  input  logic [RISC_V_DATA_WIDTH-1:0]           id_imm,
  input  logic [RISC_V_DATA_WIDTH-1:0]           id_pc,
  input  ctrl_t                                  id_ctrl,
  input  logic                                   ex_busy,
  input  logic                                   flush,
  input  logic                                   wb_reg_w,
  input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [RISC_V_DATA_WIDTH-1:0]           wb_data,
  output logic                                   idex_valid,
  output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] idex_rs1,
  output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] idex_rs2,
  output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] idex_rd,
  output logic [RISC_V_DATA_WIDTH-1:0]           idex_reg_r0,
  output logic [RISC_V_DATA_WIDTH-1:0]           idex_reg_r1,
  output logic [RISC_V_DATA_WIDTH-1:0]           idex_imm,
  output logic [RISC_V_DATA_WIDTH-1:0]           idex_pc,
  output ctrl_t                                  idex_ctrl,
  output logic                                   stall_ifid,
  output logic [CNT_WIDTH-1:0]                   lu_stall_cnt,
  output logic [CNT_WIDTH-1:0]                   flush_cnt
);

  localparam reg_idx_t             IDX_ZERO  = {REGISTER_FILE_ADDRESS_WIDTH{1'b0}};
  localparam data_t                DATA_ZERO = {RISC_V_DATA_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic  lu_s;
  data_t cap_r0_s;
  data_t cap_r1_s;

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (idex_valid),
    .ex_mem_r    (idex_ctrl.mem_r),
    .ex_rd       (idex_rd),
    .lu          (lu_s)
  );

  // Flush cancels both the hold and the load-use stall so fetch can redirect at once.
  assign stall_ifid = !flush && (ex_busy || lu_s);

  // Writeback bypass on capture: a result committing this cycle is newer than the RF read.
  always_comb begin
    cap_r0_s = id_reg_r0;
    cap_r1_s = id_reg_r1;
    if (wb_hit(wb_reg_w, wb_rd, id_rs1)) begin
      cap_r0_s = wb_data;
    end else begin
      cap_r0_s = id_reg_r0;
    end
    if (wb_hit(wb_reg_w, wb_rd, id_rs2)) begin
      cap_r1_s = wb_data;
    end else begin
      cap_r1_s = id_reg_r1;
    end
  end

  // ID/EX register update: reset > flush > EX hold (with refresh) > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      idex_valid  <= 1'b0;
      idex_rs1    <= IDX_ZERO;
      idex_rs2    <= IDX_ZERO;
      idex_rd     <= IDX_ZERO;
      idex_reg_r0 <= DATA_ZERO;
      idex_reg_r1 <= DATA_ZERO;
      idex_imm    <= DATA_ZERO;
      idex_pc     <= DATA_ZERO;
      idex_ctrl   <= CTRL_BUBBLE;
    end else if (ex_busy) begin
      if (wb_hit(wb_reg_w, wb_rd, idex_rs1)) begin
        idex_reg_r0 <= wb_data;
      end
      if (wb_hit(wb_reg_w, wb_rd, idex_rs2)) begin
        idex_reg_r1 <= wb_data;
      end
    end else if (id_valid && !lu_s) begin
      idex_valid  <= 1'b1;
      idex_rs1    <= id_rs1;
      idex_rs2    <= id_rs2;
      idex_rd     <= id_rd;
      idex_reg_r0 <= cap_r0_s;
      idex_reg_r1 <= cap_r1_s;
      idex_imm    <= id_imm;
      idex_pc     <= id_pc;
      idex_ctrl   <= id_ctrl;
    end else begin
      idex_valid  <= 1'b0;
      idex_rs1    <= IDX_ZERO;
      idex_rs2    <= IDX_ZERO;
      idex_rd     <= IDX_ZERO;
      idex_reg_r0 <= DATA_ZERO;
      idex_reg_r1 <= DATA_ZERO;
      idex_imm    <= DATA_ZERO;
      idex_pc     <= DATA_ZERO;
      idex_ctrl   <= CTRL_BUBBLE;
    end
  end

  // Saturating performance counters; a stall hidden under a hold or flush is not a load-use loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt <= CNT_ZERO;
      flush_cnt    <= CNT_ZERO;
    end else begin
      if (lu_s && !ex_busy && !flush && (lu_stall_cnt != CNT_MAX)) begin
        lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
      end
      if (flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
